// File: rtl/gnn_0_read_arbiter.sv
// rtl/gnn_0_read_arbiter.sv - round-robin sharing of one AXI read master between load units
// Each requester slot latches addr/size on its start pulse; one transfer is granted at a time.
module gnn_0_read_arbiter #(
   parameter int NUM_REQ            = 3,
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   localparam int GW                = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                    kernel_clk,
   input  logic                                    kernel_rst,
   input  logic [NUM_REQ-1:0]                      req_read_start,
   input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_xfer_start_addr,
   input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_xfer_size_in_bytes,
   output logic [NUM_REQ-1:0]                      req_read_done,
   output logic [NUM_REQ-1:0]                      req_data_tvalid,
   input  logic [NUM_REQ-1:0]                      req_data_tready,
   output logic [NUM_REQ-1:0]                      req_data_tlast,
   output logic [C_M_AXI_DATA_WIDTH-1:0]           req_data_tdata,
   output logic                                    m_read_start,
   input  logic                                    m_read_done,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]           m_xfer_start_addr,
   output logic [C_XFER_SIZE_WIDTH-1:0]            m_xfer_size_in_bytes,
   input  logic                                    m_data_tvalid,
   input  logic                                    m_data_tlast,
   output logic                                    m_data_tready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]           m_data_tdata,
   output logic [GW-1:0]                           grant_id,
   output logic                                    busy,
   output logic [NUM_REQ-1:0]                      req_overflow
);

   typedef enum logic [1:0] {IDLE, ISSUE, STREAM, FINISH} state_t;

   state_t                          state;
   logic [NUM_REQ-1:0]              pending;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   slot_addr [NUM_REQ];
   logic [C_XFER_SIZE_WIDTH-1:0]    slot_size [NUM_REQ];
   logic                            last_seen;
   logic                            done_seen;
   logic                            last_now;
   logic                            done_now;
   logic                            sel_valid;
   logic [GW-1:0]                   sel_id;
   logic                            grant_fire;
   int                              rr_dist;
   int                              rr_best;

   // Pending slot closest after the last grant (wrapping) wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = grant_id;
      rr_dist   = 0;
      rr_best   = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_dist = (i + 2*NUM_REQ - 1 - int'(grant_id)) % NUM_REQ;
         if (pending[i] && (rr_dist < rr_best)) begin
            rr_best   = rr_dist;
            sel_id    = GW'(i);
            sel_valid = 1'b1;
         end
      end
   end

   assign grant_fire = (state == IDLE) && sel_valid;

   always_comb begin
      req_data_tvalid = '0;
      req_data_tlast  = '0;
      m_data_tready   = 1'b0;
      if (state == STREAM) begin
         req_data_tvalid[grant_id] = m_data_tvalid;
         req_data_tlast[grant_id]  = m_data_tlast;
         m_data_tready             = req_data_tready[grant_id];
      end
   end

   assign last_now       = last_seen | (m_data_tvalid & m_data_tready & m_data_tlast);
   assign done_now       = done_seen | m_read_done;
   assign busy           = (state != IDLE);
   assign req_data_tdata = m_data_tdata;

   always_ff @(posedge kernel_clk) begin
      if (kernel_rst) begin
         state                <= IDLE;
         pending              <= '0;
         req_overflow         <= '0;
         last_seen            <= 1'b0;
         done_seen            <= 1'b0;
         grant_id             <= GW'(NUM_REQ-1);
         m_read_start         <= 1'b0;
         req_read_done        <= '0;
         m_xfer_start_addr    <= '0;
         m_xfer_size_in_bytes <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_addr[i] <= '0;
            slot_size[i] <= '0;
         end
      end else begin
         m_read_start  <= 1'b0;
         req_read_done <= '0;
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  grant_id             <= sel_id;
                  pending[sel_id]      <= 1'b0;
                  m_xfer_start_addr    <= slot_addr[sel_id];
                  m_xfer_size_in_bytes <= slot_size[sel_id];
                  last_seen            <= 1'b0;
                  done_seen            <= 1'b0;
                  if (slot_size[sel_id] == '0) begin
                     state                 <= FINISH;
                     req_read_done[sel_id] <= 1'b1;
                  end else begin
                     state        <= ISSUE;
                     m_read_start <= 1'b1;
                  end
               end
            end
            ISSUE: state <= STREAM;
            STREAM: begin
               last_seen <= last_now;
               done_seen <= done_now;
               if (last_now && done_now) begin
                  state                   <= FINISH;
                  req_read_done[grant_id] <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         // Placed after the grant so a same-cycle re-pulse on the granted slot re-pends it.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_read_start[i]) begin
               if (pending[i] && !(grant_fire && (sel_id == GW'(i)))) begin
                  req_overflow[i] <= 1'b1;
               end else begin
                  pending[i]   <= 1'b1;
                  slot_addr[i] <= req_xfer_start_addr[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
                  slot_size[i] <= req_xfer_size_in_bytes[i*C_XFER_SIZE_WIDTH +: C_XFER_SIZE_WIDTH];
               end
            end
         end
      end
   end

endmodule
